// File: rtl/countdown_mmss_pkg.sv
// Shared types and constants for the mm:ss countdown timer.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX_UNITS    = 4'd9;
  localparam logic [3:0] BCD_MAX_TENS_SEC = 4'd5;

  function automatic logic [3:0] clampDigit(input logic [3:0] digitIn,
                                            input logic [3:0] maxVal);
    return (digitIn > maxVal) ? maxVal : digitIn;
  endfunction

endpackage

// File: rtl/countdown_mmss_if.sv
// Control and display-digit bundle between the countdown timer and its controller.
interface countdown_mmss_if;

  logic       enin;
  logic       load;
  logic       start;
  logic       stop;
  logic [3:0] set_sec;
  logic [3:0] set_sec10;
  logic [3:0] set_min;
  logic [3:0] set_min10;

  logic [3:0] sec;
  logic [3:0] sec10;
  logic [3:0] min;
  logic [3:0] min10;
  logic       running;
  logic       done;
  logic       alarm;

  modport master (
    output enin, load, start, stop,
    output set_sec, set_sec10, set_min, set_min10,
    input  sec, sec10, min, min10, running, done, alarm
  );

  modport slave (
    input  enin, load, start, stop,
    input  set_sec, set_sec10, set_min, set_min10,
    output sec, sec10, min, min10, running, done, alarm
  );

endinterface

// File: rtl/countdown_mmss_bcd_down_digit.sv
// One BCD down-counting digit; wraps to WRAP and borrows out when decremented at 0.
module bcd_down_digit
  import countdown_pkg::*;
#(
  parameter logic [3:0] WRAP = BCD_MAX_UNITS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [3:0] i_loadVal,
  input  logic       i_clear,
  input  logic       i_borrowIn,
  output logic [3:0] o_digit,
  output logic       o_borrowOut
);

  logic [3:0] r_digit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_digit <= 4'd0;
    end else if (i_clear) begin
      r_digit <= 4'd0;
    end else if (i_load) begin
      r_digit <= i_loadVal;
    end else if (i_borrowIn) begin
      r_digit <= (r_digit == 4'd0) ? WRAP : (r_digit - 4'd1);
    end
  end

  assign o_digit     = r_digit;
  assign o_borrowOut = (r_digit == 4'd0) && i_borrowIn;

endmodule

// File: rtl/countdown_mmss.sv
// BCD mm:ss countdown timer: FSM, load sanitising, zero detect and optional alarm.
// Optional feature: define COUNTDOWN_ALARM_EN to build the expiry alarm counter.
module countdown_mmss
  import countdown_pkg::*;
#(
  parameter int ALARM_TICKS = 10
) (
  input  logic             clk,
  input  logic             rst,
  countdown_mmss_if.slave  bus
);

  state_t     r_state;
  state_t     w_nextState;
  logic       w_load;
  logic       w_clear;
  logic       w_dec;
  logic       w_isZero;
  logic       w_isOne;
  logic       r_done;

  logic [3:0] w_setSec;
  logic [3:0] w_setSec10;
  logic [3:0] w_setMin;
  logic [3:0] w_setMin10;
  logic [3:0] w_sec;
  logic [3:0] w_sec10;
  logic [3:0] w_min;
  logic [3:0] w_min10;
  logic       w_borrowSec;
  logic       w_borrowSec10;
  logic       w_borrowMin;
  logic       w_unusedBorrowMin10;

  assign w_setSec   = clampDigit(bus.set_sec,   BCD_MAX_UNITS);
  assign w_setSec10 = clampDigit(bus.set_sec10, BCD_MAX_TENS_SEC);
  assign w_setMin   = clampDigit(bus.set_min,   BCD_MAX_UNITS);
  assign w_setMin10 = clampDigit(bus.set_min10, BCD_MAX_UNITS);

  assign w_isZero = ({w_min10, w_min, w_sec10, w_sec} == 16'h0000);
  assign w_isOne  = ({w_min10, w_min, w_sec10, w_sec} == 16'h0001);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_done  <= w_dec && w_isOne;
    end
  end

  // Priority stop > load > start > enin; stop only acts in RUN and PAUSE.
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_clear     = 1'b0;
    w_dec       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.load) begin
          w_load = 1'b1;
        end else if (bus.start && !w_isZero) begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        if (bus.stop) begin
          w_nextState = PAUSE;
        end else if (bus.enin) begin
          w_dec = 1'b1;
          if (w_isOne) begin
            w_nextState = DONE;
          end
        end
      end
      PAUSE: begin
        if (bus.stop) begin
          w_clear     = 1'b1;
          w_nextState = IDLE;
        end else if (bus.load) begin
          w_load      = 1'b1;
          w_nextState = IDLE;
        end else if (bus.start) begin
          w_nextState = RUN;
        end
      end
      DONE: begin
        if (bus.load) begin
          w_load      = 1'b1;
          w_nextState = IDLE;
        end else if (bus.start) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  bcd_down_digit #(.WRAP(BCD_MAX_UNITS)) u_sec (
    .clk(clk), .rst(rst), .i_load(w_load), .i_loadVal(w_setSec), .i_clear(w_clear),
    .i_borrowIn(w_dec), .o_digit(w_sec), .o_borrowOut(w_borrowSec)
  );

  bcd_down_digit #(.WRAP(BCD_MAX_TENS_SEC)) u_sec10 (
    .clk(clk), .rst(rst), .i_load(w_load), .i_loadVal(w_setSec10), .i_clear(w_clear),
    .i_borrowIn(w_borrowSec), .o_digit(w_sec10), .o_borrowOut(w_borrowSec10)
  );

  bcd_down_digit #(.WRAP(BCD_MAX_UNITS)) u_min (
    .clk(clk), .rst(rst), .i_load(w_load), .i_loadVal(w_setMin), .i_clear(w_clear),
    .i_borrowIn(w_borrowSec10), .o_digit(w_min), .o_borrowOut(w_borrowMin)
  );

  // Never borrowed at zero: RUN always leaves before 00:00 would be decremented.
  bcd_down_digit #(.WRAP(4'd0)) u_min10 (
    .clk(clk), .rst(rst), .i_load(w_load), .i_loadVal(w_setMin10), .i_clear(w_clear),
    .i_borrowIn(w_borrowMin), .o_digit(w_min10), .o_borrowOut(w_unusedBorrowMin10)
  );

  assign bus.sec     = w_sec;
  assign bus.sec10   = w_sec10;
  assign bus.min     = w_min;
  assign bus.min10   = w_min10;
  assign bus.running = (r_state == RUN);
  assign bus.done    = r_done;

`ifdef COUNTDOWN_ALARM_EN
  localparam int CW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;

  logic          r_alarm;
  logic [CW-1:0] r_alarmCnt;

  // Alarm rises with done and counts enin ticks while parked in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alarm    <= 1'b0;
      r_alarmCnt <= '0;
    end else if (w_dec && w_isOne) begin
      r_alarm    <= 1'b1;
      r_alarmCnt <= '0;
    end else if (r_alarm) begin
      if (w_nextState != DONE) begin
        r_alarm <= 1'b0;
      end else if (bus.enin) begin
        if (r_alarmCnt == CW'(ALARM_TICKS - 1)) begin
          r_alarm <= 1'b0;
        end
        r_alarmCnt <= r_alarmCnt + CW'(1);
      end
    end
  end

  assign bus.alarm = r_alarm;
`else
  logic w_unusedTicks;
  assign w_unusedTicks = (ALARM_TICKS == 0);
  assign bus.alarm     = 1'b0;
`endif

endmodule
